// File: rtl/alu_pkg.sv
// Shared constants for the ALU sharing logic: default datapath width,
// FSM state encoding and requester IDs.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational round-robin grant. On contention the requester
// that did not win last time gets the grant; at most one grant is high.
module rr_arbiter2
    import alu_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    input  logic enable_i,
    output logic grant0_o,
    output logic grant1_o,
    output logic grant_id_o
);

    logic pick;

    always_comb begin
        pick       = ID_REQ0;
        grant0_o   = 1'b0;
        grant1_o   = 1'b0;
        grant_id_o = ID_REQ0;
        if (enable_i) begin
            if (valid0_i && valid1_i) begin
                pick = ~last_grant_i;
            end else if (valid1_i) begin
                pick = ID_REQ1;
            end
            grant0_o   = valid0_i && (pick == ID_REQ0);
            grant1_o   = valid1_i && (pick == ID_REQ1);
            grant_id_o = pick;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external adder between two requesters: round-robin accept,
// one EXEC cycle on registered operands, then a held valid/ready response.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_sum,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             cur_id_q, cur_id_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;

    logic gnt0, gnt1, gnt_id;

    rr_arbiter2 u_rr (
        .valid0_i     (req0_valid),
        .valid1_i     (req1_valid),
        .last_grant_i (last_grant_q),
        .enable_i     (state_q == IDLE),
        .grant0_o     (gnt0),
        .grant1_o     (gnt1),
        .grant_id_o   (gnt_id)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    op_a_d       = (gnt_id == ID_REQ1) ? req1_a : req0_a;
                    op_b_d       = (gnt_id == ID_REQ1) ? req1_b : req0_b;
                    cur_id_d     = gnt_id;
                    last_grant_d = gnt_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // alu_sum reflects the operand registers driven all this cycle
                rsp_data_d  = alu_sum;
                rsp_id_d    = cur_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Last grant resets to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_REQ1;
            cur_id_q     <= ID_REQ0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= ID_REQ0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [7:0] alu_a, alu_b, alu_sum, rsp_data;
    logic       rsp_valid, rsp_ready, rsp_id, busy;

    int n_vec = 0;
    int n_err = 0;

    // reference model: one transaction in flight at most
    logic       m_idle, m_exec, m_rspv, m_last, m_cur, m_rid;
    logic [7:0] m_opa, m_opb, m_data;
    int         gq[$];
    logic [8:0] rq[$];

    alu_share_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sum(alu_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy)
    );

    // behavioural stand-in for the external ALU
    assign alu_sum = alu_a + alu_b;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_exec = 1'b0; m_rspv = 1'b0;
        m_last = 1'b1; m_cur = 1'b0; m_rid = 1'b0;
        m_opa = 8'h00; m_opb = 8'h00; m_data = 8'h00;
    endtask

    task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                         input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
    endtask

    task automatic reset_dut();
        drive(0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    // one clock: apply inputs, check at the falling edge, advance model at the rising edge
    task automatic step(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                        input logic rr);
        logic e_r0, e_r1;
        logic [8:0] s;
        drive(v0, a0, b0, v1, a1, b1, rr);
        e_r0 = m_idle && v0 && (!v1 || m_last == 1'b1);
        e_r1 = m_idle && v1 && (!v0 || m_last == 1'b0);
        @(negedge clk);
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("busy", busy, !m_idle);
        chk("alu_a", alu_a, m_opa);
        chk("alu_b", alu_b, m_opb);
        chk("rsp_valid", rsp_valid, m_rspv);
        if (m_rspv) begin
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_id", rsp_id, m_rid);
        end
        if (req0_ready && req0_valid) gq.push_back(0);
        if (req1_ready && req1_valid) gq.push_back(1);
        if (rsp_valid && rsp_ready) rq.push_back({rsp_id, rsp_data});
        @(posedge clk);
        if (m_idle) begin
            if (e_r0 || e_r1) begin
                m_cur  = e_r1;
                m_opa  = e_r1 ? a1 : a0;
                m_opb  = e_r1 ? b1 : b0;
                m_last = e_r1;
                m_idle = 1'b0;
                m_exec = 1'b1;
            end
        end else if (m_exec) begin
            s      = {1'b0, m_opa} + {1'b0, m_opb};
            m_data = s[7:0];
            m_rid  = m_cur;
            m_rspv = 1'b1;
            m_exec = 1'b0;
        end else if (m_rspv && rr) begin
            m_rspv = 1'b0;
            m_idle = 1'b1;
        end
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    function automatic logic [8:0] rq_at(input int k);
        return (rq.size() > k) ? rq[k] : 9'h1FF;
    endfunction

    function automatic int gq_at(input int k);
        return (gq.size() > k) ? gq[k] : -1;
    endfunction

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        reset_dut();

        // single request after reset
        gq.delete(); rq.delete();
        step(1, 8'h12, 8'h34, 0, 0, 0, 1);
        idle_steps(3);
        chk("single_grant", gq_at(0), 0);
        chk("single_rsp", rq_at(0), {1'b0, 8'h46});

        // carry is discarded
        gq.delete(); rq.delete();
        step(0, 0, 0, 1, 8'hF0, 8'h20, 1);
        idle_steps(3);
        chk("wrap_rsp", rq_at(0), {1'b1, 8'h10});

        // continuous contention from reset
        reset_dut();
        gq.delete(); rq.delete();
        for (int i = 0; i < 12; i++) step(1, 8'h01, 8'h01, 1, 8'h02, 8'h02, 1);
        for (int k = 0; k < 4; k++) begin
            chk("cont_grant", gq_at(k), k % 2);
            chk("cont_rsp", rq_at(k), (k % 2 == 0) ? {1'b0, 8'h02} : {1'b1, 8'h04});
        end

        // backpressure with requester 0 waiting
        gq.delete(); rq.delete();
        step(1, 8'h05, 8'h06, 0, 0, 0, 1);
        step(1, 8'h07, 8'h07, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 8'h07, 8'h07, 0, 0, 0, 0);
        step(1, 8'h07, 8'h07, 0, 0, 0, 1);
        step(1, 8'h07, 8'h07, 0, 0, 0, 1);
        chk("bp_grants", gq.size(), 2);
        chk("bp_rsp", rq_at(0), {1'b0, 8'h0B});
        idle_steps(3);

        // asynchronous reset while in EXEC
        step(1, 8'hAA, 8'h55, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        chk("arst_alu_a", alu_a, 8'h00);
        model_reset();
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        rq.delete();
        idle_steps(4);
        chk("arst_no_stale", rq.size(), 0);

        // fairness after requester 1 served alone
        gq.delete();
        step(0, 0, 0, 1, 8'h03, 8'h04, 1);
        idle_steps(2);
        step(1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 1);
        idle_steps(3);
        chk("fair_first", gq_at(0), 1);
        chk("fair_next", gq_at(1), 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom),
                 $urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
